// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// Sequences FETCH/DECODE/EXE/MEM/WB and drives every datapath enable and
// select from the current state, the IR opcode/funct fields and alu_zero.
// A retired-instruction counter ticks once per completed instruction
// (illegal encodings included).
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_src,
    output logic             alu_b_src,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic             mem_we,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // State codes are visible on the state port, so they are fixed values.
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // Select encodings
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JIDX = 2'b10;
    localparam logic [1:0] PC_RS   = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_RA  = 2'b10;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] nxt;

    logic is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_rtype_alu, is_jump, is_legal;

    // Register/shamt fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^instr[25:6];

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Instruction classification from op/funct.
    always_comb begin
        is_addu = (op == 6'h00) && (funct == 6'h21);
        is_subu = (op == 6'h00) && (funct == 6'h23);
        is_jr   = (op == 6'h00) && (funct == 6'h08);
        is_ori  = (op == 6'h0d);
        is_lui  = (op == 6'h0f);
        is_lw   = (op == 6'h23);
        is_sw   = (op == 6'h2b);
        is_beq  = (op == 6'h04);
        is_j    = (op == 6'h02);
        is_jal  = (op == 6'h03);
        is_rtype_alu = is_addu | is_subu;
        is_jump      = is_j | is_jal | is_jr;
        is_legal     = is_rtype_alu | is_jump | is_ori | is_lui |
                       is_lw | is_sw | is_beq;
    end

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    // Next-state: jumps and illegal encodings finish in DECODE, beq in EXE,
    // sw in MEM, everything else in WB. Unused codes fall back to FETCH.
    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = (is_jump || !is_legal) ? S_FETCH : S_EXE;
            S_EXE: begin
                if (is_lw || is_sw)                         nxt = S_MEM;
                else if (is_rtype_alu || is_ori || is_lui)  nxt = S_WB;
                else                                        nxt = S_FETCH;
            end
            S_MEM:    nxt = is_lw ? S_WB : S_FETCH;
            S_WB:     nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    // Moore outputs per state, qualified by instruction fields and alu_zero.
    // Reset overrides every enable and pulse so an abandoned instruction
    // cannot commit anything while reset is held.
    always_comb begin
        pc_we      = 1'b0;
        pc_src     = PC_INC;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        wd_src     = WD_ALU;
        alu_b_src  = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        mem_we     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                ir_we  = 1'b1;
                pc_we  = 1'b1;
                pc_src = PC_INC;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JIDX;
                end
                if (is_jal) begin
                    // PC already holds PC+4 here, which is the link value.
                    pc_we   = 1'b1;
                    pc_src  = PC_JIDX;
                    reg_we  = 1'b1;
                    reg_dst = DST_RA;
                    wd_src  = WD_PC;
                end
                if (is_jr) begin
                    pc_we  = 1'b1;
                    pc_src = PC_RS;
                end
                illegal    = !is_legal;
                instr_done = is_jump || !is_legal;
            end
            S_EXE: begin
                if (is_addu) alu_op = ALU_ADD;
                if (is_subu) alu_op = ALU_SUB;
                if (is_ori) begin
                    alu_op    = ALU_OR;
                    ext_op    = EXT_ZERO;
                    alu_b_src = 1'b1;
                end
                if (is_lui) begin
                    // Upper-immediate OR'd with rs; correct only when rs is $0.
                    alu_op    = ALU_OR;
                    ext_op    = EXT_LUI;
                    alu_b_src = 1'b1;
                end
                if (is_lw || is_sw) begin
                    alu_op    = ALU_ADD;
                    ext_op    = EXT_SIGN;
                    alu_b_src = 1'b1;
                end
                if (is_beq) begin
                    // Compare rs/rt by subtraction; B comes from the GRF.
                    alu_op     = ALU_SUB;
                    ext_op     = EXT_SIGN;
                    pc_we      = alu_zero;
                    pc_src     = alu_zero ? PC_BR : PC_INC;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_we     = is_sw;
                instr_done = is_sw;
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_rtype_alu ? DST_RD : DST_RT;
                wd_src     = is_lw ? WD_MEM : WD_ALU;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // Retired-instruction counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset)           retired <= '0;
        else if (instr_done) retired <= retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven and randomized check of mc_ctrl against a
// cycle-index reference model (each instruction is a list of phases).
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        pc_we, ir_we, reg_we, mem_we, alu_b_src, instr_done, illegal;
    logic [1:0]  pc_src, reg_dst, wd_src, ext_op;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_src(wd_src), .alu_b_src(alu_b_src),
        .ext_op(ext_op), .alu_op(alu_op), .mem_we(mem_we), .state(state),
        .instr_done(instr_done), .illegal(illegal), .retired(retired)
    );

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_b_src;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       mem_we;
        logic [2:0] state;
        logic       done;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          ncyc;
        logic [2:0]  last_state;
    } vec_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4,
                   K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    function automatic int kind_of(logic [31:0] w);
        case (w[31:26])
            6'h00: case (w[5:0])
                       6'h21: return K_ADDU;
                       6'h23: return K_SUBU;
                       6'h08: return K_JR;
                       default: return K_ILL;
                   endcase
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int cycles_of(int kd);
        if (kd == K_J || kd == K_JAL || kd == K_JR || kd == K_ILL) return 2;
        if (kd == K_BEQ) return 3;
        if (kd == K_LW)  return 5;
        return 4;
    endfunction

    // Expected controls in cycle k of an instruction of kind kd.
    function automatic ctl_t exp_ctl(int kd, int k, logic z);
        ctl_t e;
        int   ph;
        e = '0;
        if (k <= 2)      ph = k;
        else if (k == 3) ph = (kd == K_LW || kd == K_SW) ? 3 : 4;
        else             ph = 4;
        e.state = 3'(ph);
        e.done  = (k == cycles_of(kd) - 1);
        case (ph)
            0: begin e.ir_we = 1; e.pc_we = 1; end
            1: begin
                if (kd == K_J)   begin e.pc_we = 1; e.pc_src = 2; end
                if (kd == K_JAL) begin
                    e.pc_we = 1; e.pc_src = 2; e.reg_we = 1; e.reg_dst = 2; e.wd_src = 2;
                end
                if (kd == K_JR)  begin e.pc_we = 1; e.pc_src = 3; end
                if (kd == K_ILL) e.ill = 1;
            end
            2: begin
                case (kd)
                    K_SUBU: e.alu_op = 1;
                    K_ORI:  begin e.alu_op = 2; e.alu_b_src = 1; end
                    K_LUI:  begin e.alu_op = 2; e.ext_op = 2; e.alu_b_src = 1; end
                    K_LW, K_SW: begin e.ext_op = 1; e.alu_b_src = 1; end
                    K_BEQ: begin
                        e.alu_op = 1; e.ext_op = 1;
                        if (z) begin e.pc_we = 1; e.pc_src = 1; end
                    end
                    default: ;
                endcase
            end
            3: e.mem_we = (kd == K_SW);
            default: begin
                e.reg_we  = 1;
                e.reg_dst = (kd == K_ADDU || kd == K_SUBU) ? 2'd1 : 2'd0;
                e.wd_src  = (kd == K_LW) ? 2'd1 : 2'd0;
            end
        endcase
        return e;
    endfunction

    function automatic ctl_t act_ctl();
        ctl_t a;
        a = {pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src, alu_b_src,
             ext_op, alu_op, mem_we, state, instr_done, illegal};
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive, settle, compare, advance to the next falling edge.
    task automatic step(input logic [31:0] w, input logic z, input int k);
        ctl_t e;
        instr    = w;
        alu_zero = z;
        #1;
        e = exp_ctl(kind_of(w), k, z);
        chk($sformatf("ctl %h k%0d", w, k), 64'(act_ctl()), 64'(e));
        chk($sformatf("retired %h k%0d", w, k), 64'(retired), 64'(exp_ret));
        if (e.done) exp_ret++;
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] w, input logic z, input int n);
        for (int k = 0; k < n; k++) step(w, z, k);
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{32'h00221821, 1'b0, 4, 3'd4};  // addu
        tbl[1]  = '{32'h8c050004, 1'b0, 5, 3'd4};  // lw
        tbl[2]  = '{32'hac050008, 1'b0, 4, 3'd3};  // sw
        tbl[3]  = '{32'h10220003, 1'b1, 3, 3'd2};  // beq taken
        tbl[4]  = '{32'h10220003, 1'b0, 3, 3'd2};  // beq not taken
        tbl[5]  = '{32'h0c000c00, 1'b0, 2, 3'd1};  // jal
        tbl[6]  = '{32'h03e00008, 1'b0, 2, 3'd1};  // jr $31
        tbl[7]  = '{32'hfc000000, 1'b0, 2, 3'd1};  // illegal
        tbl[8]  = '{32'h3421ffff, 1'b0, 4, 3'd4};  // ori
        tbl[9]  = '{32'h3c011234, 1'b0, 4, 3'd4};  // lui
        tbl[10] = '{32'h00221823, 1'b1, 4, 3'd4};  // subu
        tbl[11] = '{32'h08000010, 1'b0, 2, 3'd1};  // j

        // Reset held for two edges: no enables, no pulses.
        reset = 1'b1; instr = '0; alu_zero = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset enables", 64'({pc_we, ir_we, reg_we, mem_we, instr_done, illegal}), 64'(0));
        end
        reset = 1'b0; #1;
        chk("post-reset fetch", 64'({state, ir_we, pc_we, pc_src}), 64'({3'd0, 1'b1, 1'b1, 2'b00}));
        chk("post-reset retired", 64'(retired), 64'(0));
        exp_ret = 0;

        // Table vectors: per-cycle model compare plus table cycle count/final state.
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].ncyc; k++) begin
                if (k == tbl[i].ncyc - 1) begin
                    instr = tbl[i].instr; alu_zero = tbl[i].zero; #1;
                    chk($sformatf("tbl%0d last", i), 64'({state, instr_done}),
                        64'({tbl[i].last_state, 1'b1}));
                end
                step(tbl[i].instr, tbl[i].zero, k);
            end
        end
        #1;
        chk("tbl end fetch", 64'(state), 64'(0));
        chk("tbl retired", 64'(retired), 64'(12));

        // Reset during lw MEM: nothing commits, counter clears.
        for (int k = 0; k < 3; k++) step(32'h8c050004, 1'b0, k);
        reset = 1'b1; #1;
        chk("rst-mem state", 64'(state), 64'(3));
        chk("rst-mem enables", 64'({pc_we, ir_we, reg_we, mem_we, instr_done, illegal}), 64'(0));
        @(negedge clk);
        reset = 1'b0; #1;
        chk("rst-mem after", 64'({state, reg_we}), 64'({3'd0, 1'b0}));
        chk("rst-mem retired", 64'(retired), 64'(0));
        exp_ret = 0;

        // Randomized instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            logic        z;
            int          pick;
            w    = $urandom;
            z    = 1'($urandom);
            pick = $urandom_range(0, 11);
            case (pick)
                0: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
                1: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
                2: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
                3: w[31:26] = 6'h0d;
                4: w[31:26] = 6'h0f;
                5: w[31:26] = 6'h23;
                6: w[31:26] = 6'h2b;
                7: w[31:26] = 6'h04;
                8: w[31:26] = 6'h02;
                9: w[31:26] = 6'h03;
                10: w[31:26] = 6'h00;  // R-type with random funct
                default: ;             // fully random word
            endcase
            run_instr(w, z, cycles_of(kind_of(w)));
        end
        #1;
        chk("final retired", 64'(retired), 64'(exp_ret));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles and drives every enable and select line. The datapath is the PC, IR, GRF, extender, ALU and DM of the CPU, with IR, A/B and ALUOut latches. It sits beside the datapath in the top-level mips and replaces the single-cycle combinational controller.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; the only reset
- instr  in  32  current IR contents (the register loaded when ir_we is high)
- alu_zero  in  1  ALU equal flag, valid in the EXE cycle
- pc_we  out  1  PC load enable
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump index, 11 GRF rs
- ir_we  out  1  IR load enable
- reg_we  out  1  GRF write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_src  out  2  00 ALUOut, 01 DM read data, 10 PC (already PC+4)
- alu_b_src  out  1  0 GRF rt, 1 extended immediate
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_op  out  3  000 add, 001 sub, 010 or
- mem_we  out  1  DM write enable
- state  out  3  current FSM state code
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
- retired  out  CNT_W  count of completed instructions, including illegal ones

Behaviour:
- Supported encodings (op/funct in hex):
  - addu 00/21, subu 00/23, jr 00/08
  - ori 0d, lui 0f, lw 23, sw 2b, beq 04, j 02, jal 03
  - Anything else is illegal.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 are unreachable and return to FETCH.
- Outputs are Moore-style from state, plus instr fields and alu_zero. Any output not listed for a state is 0.
- FETCH:
  - ir_we=1, pc_we=1, pc_src=00.
  - Next state is DECODE.
- DECODE:
  - j: pc_we=1, pc_src=10.
  - jal: pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wd_src=10. $31 gets the old PC+4.
  - jr: pc_we=1, pc_src=11.
  - Next state: j/jal/jr/illegal go to FETCH; all others go to EXE.
- EXE:
  - addu: alu_op=000, alu_b_src=0. subu: alu_op=001, alu_b_src=0.
  - ori: alu_op=010, ext_op=00, alu_b_src=1.
  - lui: alu_op=010, ext_op=10, alu_b_src=1. The A operand is treated as 0 by the datapath via $0 only if rs=0; the controller does not enforce this.
  - lw/sw: alu_op=000, ext_op=01, alu_b_src=1.
  - beq: alu_op=001, ext_op=01. If alu_zero=1, pc_we=1 and pc_src=01. Next state is FETCH.
  - Next state: lw/sw go to MEM; R-type, ori and lui go to WB.
- MEM:
  - sw: mem_we=1, next state FETCH.
  - lw: no write, next state WB.
- WB:
  - reg_we=1.
  - reg_dst=01 for addu/subu, 00 otherwise.
  - wd_src=01 for lw, 00 otherwise.
  - Next state is FETCH.
- Cycle counts: j/jal/jr/illegal 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- instr_done:
  - High in the last cycle of each instruction: DECODE for 2-cycle ops, EXE for beq, MEM for sw, WB otherwise.
  - retired increments by 1 on the clock edge that ends that cycle. It wraps modulo 2^CNT_W with no saturation.
- Writes to $0 are not filtered here; the GRF ignores them.
- Reset:
  - While reset=1, every enable (pc_we, ir_we, reg_we, mem_we) is forced to 0 and instr_done and illegal are 0.
  - At the next edge: state goes to FETCH and retired goes to 0.
  - A reset in mid-instruction abandons it with no partial write after the reset edge.
  - After reset falls, the first cycle is FETCH.
- instr is assumed stable from DECODE until the instruction ends, since IR loads only in FETCH.

Test Plan:
- Reset held 2 cycles, then released -> state=0, ir_we=1, pc_we=1, pc_src=00, retired=0.
- addu $3,$1,$2 (0x00221821) -> states 0,1,2,4 then 0; WB shows reg_we=1, reg_dst=01, wd_src=00; retired=1.
- lw $5,4($0) (0x8c050004) then sw $5,8($0) (0xac050008):
  - lw: states 0,1,2,3,4; EXE ext_op=01, alu_b_src=1; WB wd_src=01; mem_we never 1.
  - sw: states 0,1,2,3; mem_we=1 only in MEM.
  - retired=2.
- beq (0x10220003): with alu_zero=1 in EXE -> pc_we=1, pc_src=01, 3 cycles. With alu_zero=0 -> pc_we=0 in EXE.
- jal (0x0c000c00) -> in DECODE: pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wd_src=10, instr_done=1; next state FETCH. jr $31 (0x03e00008) -> pc_src=11 in DECODE.
- Illegal 0xfc000000 -> illegal pulses 1 cycle in DECODE with no enables; back to FETCH; retired increments. Reset asserted during lw MEM -> no reg_we in the following cycle; state=0; retired=0.
